// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential add/subtract unit: FSM state
// encodings and the operation-mode encoding used for result formatting.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation mode is {signed_mode, sub}.
  localparam logic [1:0] MODE_UADD = 2'b00;
  localparam logic [1:0] MODE_USUB = 2'b01;
  localparam logic [1:0] MODE_SADD = 2'b10;
  localparam logic [1:0] MODE_SSUB = 2'b11;

  function automatic logic [1:0] mode_of(input logic signed_mode, input logic sub);
    return {signed_mode, sub};
  endfunction

endpackage

// File: rtl/seq_addsub_digit_adder.sv
// Combinational ripple-carry slice adding DIGIT bits per clock. Also exposes
// the carry into its top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  // Ripple the carry through the slice bit by bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT - 1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract unit. Consumes DIGIT bits of each operand per
// clock, LSB first, and assembles a WIDTH+1 bit exact result.
//
// Handshake: start is sampled on any rising edge where the FSM is in IDLE or
// DONE (busy=0); that edge latches a, b, sub and signed_mode. While busy=1,
// start and operand inputs are ignored and nothing is queued. done is a
// single-cycle pulse marking sum/overflow valid; sum/overflow then hold until
// the next accepted operation completes or reset.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output state_e           dbg_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("seq_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dg_s;
  logic             dg_cout;
  logic             dg_cmsb;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH:0]   fmt_sum;
  logic             fmt_ovf;
  logic             fmt_v;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (opa_q[DIGIT-1:0]),
    .y        (opb_q[DIGIT-1:0]),
    .cin      (carry_q),
    .s        (dg_s),
    .cout     (dg_cout),
    .c_msb_in (dg_cmsb)
  );

  // Result shift register: new digit enters at the MSB end.
  always_comb begin
    res_next = res_q >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = dg_s;
  end

  // Final-edge result formatting; only meaningful on the last CALC step.
  always_comb begin
    fmt_v   = dg_cmsb ^ dg_cout;
    fmt_sum = '0;
    fmt_ovf = 1'b0;
    unique case (mode_q)
      MODE_UADD: begin
        fmt_sum = {dg_cout, res_next};
        fmt_ovf = dg_cout;
      end
      MODE_USUB: begin
        fmt_sum = {~dg_cout, res_next};
        fmt_ovf = ~dg_cout;
      end
      MODE_SADD, MODE_SSUB: begin
        fmt_sum = {res_next[WIDTH-1] ^ fmt_v, res_next};
        fmt_ovf = fmt_v;
      end
      default: begin
        fmt_sum = '0;
        fmt_ovf = 1'b0;
      end
    endcase
  end

  // Next-state logic for the FSM, counter and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry.
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          mode_d  = mode_of(signed_mode, sub);
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_CALC;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_next;
        carry_d = dg_cout;
        if (cnt_q == LAST) begin
          // Counter parks at STEPS-1; it is cleared on the next acceptance.
          sum_d   = fmt_sum;
          ovf_d   = fmt_ovf;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      mode_q  <= MODE_UADD;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub at WIDTH=16 with DIGIT=1 (dut1) and DIGIT=4 (dut4).
// Both share operand inputs; each has its own start so handshake scenarios
// can target dut1 alone.
module tb_seq_addsub;
  import seq_addsub_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        sub = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic [16:0] sum1, sum4;
  logic        done1, done4, busy1, busy4, ovf1, ovf4;
  state_e      dbg1, dbg4;

  int checks = 0;
  int errors = 0;

  seq_addsub #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub), .signed_mode(sgn),
    .a(a), .b(b), .sum(sum1), .done(done1), .busy(busy1), .overflow(ovf1),
    .dbg_state(dbg1)
  );

  seq_addsub #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub), .signed_mode(sgn),
    .a(a), .b(b), .sum(sum4), .done(done4), .busy(busy4), .overflow(ovf4),
    .dbg_state(dbg4)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: exact arithmetic on extended operands.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic ms, input logic msg);
    logic [16:0] ea, eb, r;
    logic        o;
    ea = msg ? {ma[15], ma} : {1'b0, ma};
    eb = msg ? {mb[15], mb} : {1'b0, mb};
    r  = ms ? (ea - eb) : (ea + eb);
    if (msg)     o = (r[16] != r[15]);
    else if (ms) o = (ma < mb);
    else         o = r[16];
    return {o, r};
  endfunction

  // One operation on both DUTs; inputs are scrambled after acceptance.
  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tsg,
                        input logic [16:0] es, input logic eo);
    bit got1, got4;
    int lat1, lat4;
    a = ta; b = tb_v; sub = ts; sgn = tsg; start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts; sgn = ~tsg;
    got1 = 0; got4 = 0; lat1 = 0; lat4 = 0;
    for (int n = 1; n <= 40 && !(got1 && got4); n++) begin
      tick();
      if (!got1) begin
        checks++;
        if (busy1 !== !done1) begin
          errors++;
          $display("FAIL %s busy_vs_done cycle %0d: busy=%b done=%b required busy=~done", name, n, busy1, done1);
        end
      end
      if (!got1 && done1 === 1'b1) begin
        got1 = 1; lat1 = n;
        checks++;
        if (sum1 !== es || ovf1 !== eo) begin
          errors++;
          $display("FAIL %s d1 result: sum=%h ovf=%b required sum=%h ovf=%b", name, sum1, ovf1, es, eo);
        end
      end
      if (!got4 && done4 === 1'b1) begin
        got4 = 1; lat4 = n;
        checks++;
        if (sum4 !== es || ovf4 !== eo) begin
          errors++;
          $display("FAIL %s d4 result: sum=%h ovf=%b required sum=%h ovf=%b", name, sum4, ovf4, es, eo);
        end
      end
    end
    checks++;
    if (!got1 || lat1 != 16) begin
      errors++;
      $display("FAIL %s d1 latency: got=%0d cycles=%0d required 16", name, got1, lat1);
    end
    checks++;
    if (!got4 || lat4 != 4) begin
      errors++;
      $display("FAIL %s d4 latency: got=%0d cycles=%0d required 4", name, got4, lat4);
    end
    tick();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || sum1 !== es || ovf1 !== eo) begin
      errors++;
      $display("FAIL %s d1 after_done: done=%b busy=%b sum=%h ovf=%b required 0 0 %h %b",
               name, done1, busy1, sum1, ovf1, es, eo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (dbg1 !== ST_IDLE || sum1 !== '0 || done1 !== 0 || busy1 !== 0 || ovf1 !== 0 ||
        sum4 !== '0 || done4 !== 0 || busy4 !== 0 || ovf4 !== 0) begin
      errors++;
      $display("FAIL reset_state: st=%0d sum1=%h d=%b b=%b o=%b sum4=%h required all zero/IDLE",
               dbg1, sum1, done1, busy1, ovf1, sum4);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op("uadd_100_200",    16'd100,  16'd200,  1'b0, 1'b0, 17'h0012C, 1'b0);
    run_op("sadd_max_max",    16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 17'h0FFFE, 1'b1);
    run_op("uadd_ffff_1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b1);
    run_op("usub_5_7",        16'd5,    16'd7,    1'b1, 1'b0, 17'h1FFFE, 1'b1);
    run_op("ssub_min_1",      16'h8000, 16'h0001, 1'b1, 1'b1, 17'h17FFF, 1'b1);
    run_op("usub_7_5",        16'd7,    16'd5,    1'b1, 1'b0, 17'h00002, 1'b0);
    run_op("sadd_m1_m1",      16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 17'h1FFFE, 1'b0);
    run_op("ssub_3_5",        16'd3,    16'd5,    1'b1, 1'b1, 17'h1FFFE, 1'b0);
    run_op("ssub_max_m1",     16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 17'h08000, 1'b1);
    run_op("usub_0_0",        16'd0,    16'd0,    1'b1, 1'b0, 17'h00000, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rs, rsg;
    logic [17:0] m;
    for (int i = 0; i < 48; i++) begin
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      rs  = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      m   = model(ra, rb, rs, rsg);
      run_op("random", ra, rb, rs, rsg, m[16:0], m[17]);
    end
  endtask

  task automatic test_busy_ignore();
    bit got;
    int lat;
    a = 16'd1000; b = 16'd234; sub = 1'b0; sgn = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (3) tick();
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; sgn = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0; a = 16'h0001;
    got = 0; lat = 4;
    for (int n = 5; n <= 40 && !got; n++) begin
      tick();
      if (done1 === 1'b1) begin got = 1; lat = n; end
    end
    checks++;
    if (!got || lat != 16 || sum1 !== 17'h004D2 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: got=%0d lat=%0d sum=%h ovf=%b required lat 16 sum 004d2 ovf 0",
               got, lat, sum1, ovf1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit got;
    int lat;
    a = 16'd10; b = 16'd20; sub = 1'b0; sgn = 1'b0; start1 = 1'b1;
    tick();
    got = 0; lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      tick();
      if (done1 === 1'b1) begin got = 1; lat = n; end
    end
    checks++;
    if (!got || lat != 16 || sum1 !== 17'd30) begin
      errors++;
      $display("FAIL b2b_first: got=%0d lat=%0d sum=%h required lat 16 sum 0001e", got, lat, sum1);
    end
    a = 16'd50; b = 16'd60;
    tick();
    start1 = 1'b0; a = '0; b = '0;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b required done 0 busy 1", done1, busy1);
    end
    got = 0; lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      tick();
      if (done1 === 1'b1) begin got = 1; lat = n; end
    end
    checks++;
    if (!got || lat != 16 || sum1 !== 17'd110 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got=%0d lat=%0d sum=%h ovf=%b required lat 16 sum 0006e ovf 0",
               got, lat, sum1, ovf1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_pulse: done=%b required 0", done1);
    end
  endtask

  task automatic test_reset_mid_calc();
    int extra_done;
    a = 16'h1234; b = 16'h0001; sub = 1'b0; sgn = 1'b0; start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0; a = 16'hAAAA; b = 16'h5555;
    repeat (5) tick();
    checks++;
    if (busy1 !== 1'b1 || sum4 !== 17'h01235) begin
      errors++;
      $display("FAIL pre_reset: busy1=%b sum4=%h required busy1 1 sum4 01235", busy1, sum4);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dbg1 !== ST_IDLE || sum1 !== '0 || done1 !== 0 || busy1 !== 0 || ovf1 !== 0 ||
        sum4 !== '0 || done4 !== 0 || busy4 !== 0) begin
      errors++;
      $display("FAIL mid_reset: st=%0d sum1=%h d=%b b=%b o=%b sum4=%h required all zero/IDLE",
               dbg1, sum1, done1, busy1, ovf1, sum4);
    end
    reset = 1'b0;
    extra_done = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done1 !== 1'b0 || busy1 !== 1'b0) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: active cycles=%0d required 0", extra_done);
    end
    run_op("after_reset", 16'h1234, 16'h0001, 1'b0, 1'b0, 17'h01235, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
